// File: rtl/crc32_64bit_check_pkg.sv
// Shared CRC-32 (IEEE 802.3) constants, checker FSM states and the bit-reflect helper.
// Combinational helpers only; no latency, no flow control.
package crc32_64bit_check_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_64bit_check_d64.sv
// CRC32_D64: combinational MSB-first CRC-32 update over one 64-bit word (unreflected state).
// Zero latency, no flow control.
module crc32_64bit_check_d64
  import crc32_64bit_check_pkg::*;
(
  input  logic [63:0] data_in,
  input  logic [31:0] crc_last,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_last;
    for (int i = 63; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data_in[i]) ? CRC32_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc32_64bit_check.sv
// Streaming CRC-32 frame checker; result 1 cycle after eop, no backpressure (every valid word accepted).
// Define CRC32_CHK_STATS_EN to add saturating frame_cnt/err_cnt outputs.
module crc32_64bit_check
  import crc32_64bit_check_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] data,
  input  logic        datavalid,
  input  logic        sop,
  input  logic        eop,
  input  logic [31:0] fcs,
  output logic [31:0] crc_out,
  output logic        crc_done,
  output logic        crc_ok,
  output logic        proto_err
`ifdef CRC32_CHK_STATS_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt
`endif
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  state_t        state;
  logic [31:0]   crc_acc;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] cnt_inc;

  logic [63:0] word_in;
  logic [31:0] crc_last;
  logic [31:0] next_crc;
  logic [31:0] crc_final;
  logic        finish, stray, overflow, restart_err, perr;

  // Byte 0 must enter the MSB-first engine first, bit 0 leading: reverse every byte and the byte order.
  always_comb begin
    word_in = '0;
    for (int k = 0; k < 8; k++) word_in[63-8*k -: 8] = reflect8(data[8*k +: 8]);
  end

  assign crc_last = (sop || state == IDLE) ? CRC32_INIT : crc_acc;

  crc32_64bit_check_d64 u_d64 (
    .data_in  (word_in),
    .crc_last (crc_last),
    .crc_out  (next_crc)
  );

  assign crc_final = CRC32_XOROUT ^ {reflect8(next_crc[7:0]),   reflect8(next_crc[15:8]),
                                     reflect8(next_crc[23:16]), reflect8(next_crc[31:24])};

  assign cnt_inc     = word_cnt + CW'(1);
  assign finish      = datavalid && eop && (sop || state == ACC);
  assign restart_err = datavalid && sop && state == ACC;
  assign stray       = datavalid && !sop && state == IDLE;
  // A frame that fills MAX_WORDS without eop is cut off here; its tail then arrives as stray words.
  assign overflow    = datavalid && !eop &&
                       ((sop && (MAX_WORDS <= 1)) || (!sop && state == ACC && cnt_inc == MAX_CNT));
  assign perr        = restart_err || stray || overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      crc_acc   <= CRC32_INIT;
      word_cnt  <= '0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      crc_done  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      crc_done  <= finish;
      proto_err <= perr;
      if (finish) begin
        crc_out <= crc_final;
        crc_ok  <= (crc_final == fcs);
      end
      if (datavalid) begin
        if (finish || overflow || stray) begin
          state    <= IDLE;
          crc_acc  <= CRC32_INIT;
          word_cnt <= '0;
        end else begin
          state    <= ACC;
          crc_acc  <= next_crc;
          word_cnt <= sop ? CW'(1) : cnt_inc;
        end
      end
    end
  end

`ifdef CRC32_CHK_STATS_EN
  logic        mismatch;
  logic [32:0] err_sum;

  assign mismatch = finish && (crc_final != fcs);
  assign err_sum  = {1'b0, err_cnt} + 33'(perr) + 33'(mismatch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (finish && frame_cnt != 32'hFFFFFFFF) frame_cnt <= frame_cnt + 32'd1;
      err_cnt <= err_sum[32] ? 32'hFFFFFFFF : err_sum[31:0];
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_crc32_64bit_check.sv
// Self-checking bench for crc32_64bit_check: constant vectors, corner sequences, random frames vs a byte-level model.
module tb_crc32_64bit_check;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] data;
  logic        datavalid, sop, eop;
  logic [31:0] fcs;
  logic [31:0] crc_out;
  logic        crc_done, crc_ok, proto_err;
`ifdef CRC32_CHK_STATS_EN
  logic [31:0] frame_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  crc32_64bit_check #(.MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data      (data),
    .datavalid (datavalid),
    .sop       (sop),
    .eop       (eop),
    .fcs       (fcs),
    .crc_out   (crc_out),
    .crc_done  (crc_done),
    .crc_ok    (crc_ok),
    .proto_err (proto_err)
`ifdef CRC32_CHK_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame kept as a byte queue, CRC computed by the textbook reflected bitwise loop.
  logic [7:0]  fbytes[$];
  bit          in_frame;
  int          nwords;
  logic [31:0] m_crc;
  bit          m_ok, m_done, m_perr;
  int          m_frames, m_errs;

  function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void push_word(input logic [63:0] d);
    for (int k = 0; k < 8; k++) fbytes.push_back(d[8*k +: 8]);
  endfunction

  function automatic logic [31:0] exp_fcs(input bit s, input logic [63:0] d);
    logic [7:0] t[$];
    if (!s) t = fbytes;
    for (int k = 0; k < 8; k++) t.push_back(d[8*k +: 8]);
    return crc_ref(t);
  endfunction

  function automatic void model_reset();
    fbytes.delete();
    in_frame = 0; nwords = 0;
    m_crc = 32'h0; m_ok = 0; m_done = 0; m_perr = 0;
    m_frames = 0; m_errs = 0;
  endfunction

  function automatic void finish_frame(input logic [31:0] f);
    m_crc = crc_ref(fbytes);
    m_ok = (m_crc == f);
    m_done = 1;
    in_frame = 0;
    m_frames++;
    if (!m_ok) m_errs++;
  endfunction

  function automatic void model_step(input bit v, input bit s, input bit e,
                                     input logic [63:0] d, input logic [31:0] f);
    m_done = 0; m_perr = 0;
    if (v) begin
      if (s) begin
        if (in_frame) m_perr = 1;
        fbytes.delete();
        push_word(d);
        nwords = 1;
        if (e) finish_frame(f);
        else if (nwords >= MAXW) begin m_perr = 1; in_frame = 0; end
        else in_frame = 1;
      end else if (!in_frame) begin
        m_perr = 1;
      end else begin
        push_word(d);
        nwords++;
        if (e) finish_frame(f);
        else if (nwords == MAXW) begin m_perr = 1; in_frame = 0; end
      end
    end
    if (m_perr) m_errs++;
  endfunction

  task automatic step(input bit v, input bit s, input bit e,
                      input logic [63:0] d, input logic [31:0] f);
    datavalid = v; sop = s; eop = e; data = d; fcs = f;
    model_step(v, s, e, d, f);
    @(posedge clk);
    #1;
    check("crc_done",  crc_done,  m_done);
    check("proto_err", proto_err, m_perr);
    check("crc_out",   crc_out,   m_crc);
    check("crc_ok",    crc_ok,    m_ok);
    datavalid = 0; sop = 0; eop = 0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  typedef struct {
    logic [63:0] d;
    logic [31:0] f;
    logic [31:0] exp_crc;
    bit          exp_ok;
  } vec_t;
  vec_t tbl[4];

  logic [63:0] d;
  logic [31:0] gap_crc;
  bit          v, s, e;

  initial begin
    reset_n = 0; datavalid = 0; sop = 0; eop = 0; data = '0; fcs = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_crc_out",   crc_out,   0);
    check("rst_crc_done",  crc_done,  0);
    check("rst_crc_ok",    crc_ok,    0);
    check("rst_proto_err", proto_err, 0);
    reset_n = 1;

    // Single-word frames back to back, against known CRC-32 constants.
    tbl[0] = '{64'h3837363534333231, 32'h9AE0DAAF, 32'h9AE0DAAF, 1'b1};
    tbl[1] = '{64'h0,                32'h6522DF69, 32'h6522DF69, 1'b1};
    tbl[2] = '{64'h0,                32'h6522DF68, 32'h6522DF69, 1'b0};
    tbl[3] = '{64'h3837363534333231, 32'h00000000, 32'h9AE0DAAF, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, tbl[i].d, tbl[i].f);
      check("tbl_done", crc_done, 1);
      check("tbl_crc",  crc_out,  tbl[i].exp_crc);
      check("tbl_ok",   crc_ok,   tbl[i].exp_ok);
    end

    // Two zero words with idle gaps, then the same frame without gaps.
    step(1, 1, 0, 64'h0, 32'h0);
    repeat (3) step(0, 0, 0, rnd64(), $urandom);
    step(1, 0, 1, 64'h0, 32'h0);
    gap_crc = crc_out;
    step(1, 1, 0, 64'h0, 32'h0);
    step(1, 0, 1, 64'h0, gap_crc);
    check("gap_equals_nogap", crc_ok, 1);

    // sop in the middle of a frame restarts it.
    step(1, 1, 0, rnd64(), 32'h0);
    step(1, 0, 0, rnd64(), 32'h0);
    d = rnd64(); step(1, 1, 0, d, 32'h0);
    check("restart_perr", proto_err, 1);
    d = rnd64(); step(1, 0, 1, d, exp_fcs(0, d));
    check("restart_ok", crc_ok, 1);

    // Stray words outside a frame.
    step(1, 0, 0, rnd64(), 32'h0);
    step(1, 0, 1, rnd64(), 32'h0);

    // Exactly MAXW words is legal; MAXW+1 is cut off.
    step(1, 1, 0, rnd64(), 32'h0);
    repeat (MAXW - 2) step(1, 0, 0, rnd64(), 32'h0);
    d = rnd64(); step(1, 0, 1, d, exp_fcs(0, d));
    check("maxw_frame_ok", crc_ok, 1);
    step(1, 1, 0, rnd64(), 32'h0);
    repeat (MAXW - 1) step(1, 0, 0, rnd64(), 32'h0);
    check("overflow_perr", proto_err, 1);
    step(1, 0, 1, rnd64(), 32'h0);
    check("overflow_no_done", crc_done, 0);

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    step(1, 1, 1, 64'h3837363534333231, 32'h9AE0DAAF);
    step(1, 1, 0, rnd64(), 32'h0);
    #2 reset_n = 0;
    #1;
    check("async_rst_crc_out", crc_out, 0);
    check("async_rst_crc_ok",  crc_ok,  0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1;
    d = rnd64(); step(1, 1, 1, d, exp_fcs(1, d));
    check("post_rst_ok", crc_ok, 1);

    // Random traffic, mostly well-formed with occasional protocol faults and wrong FCS.
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(3) != 0);
      s = in_frame ? ($urandom_range(11) == 0) : ($urandom_range(9) != 0);
      e = ($urandom_range(2) == 0);
      d = rnd64();
      step(v, s, e, d, $urandom_range(1) ? exp_fcs(s, d) : $urandom);
    end

`ifdef CRC32_CHK_STATS_EN
    check("frame_cnt", frame_cnt, m_frames);
    check("err_cnt",   err_cnt,   m_errs);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
